// File: rtl/button_input_pkg.sv
// Shared encoder state encodings, debounce defaults and button-vector helpers
// for the colour/start button front end.
package button_input_pkg;

  typedef enum logic [1:0] {
    ENC_IDLE = 2'd0,
    ENC_HELD = 2'd1,
    ENC_WAIT = 2'd2
  } enc_state_e;

  localparam int DEBOUNCE_10MS = 250000;
  localparam int DB_W_DEFAULT  = 18;
  localparam int NUM_BTN       = 4;

  function automatic logic [2:0] btn_count(input logic [NUM_BTN-1:0] b);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_BTN; i++) n = n + {2'b00, b[i]};
    return n;
  endfunction

  // Only meaningful when exactly one bit is set.
  function automatic logic [1:0] btn_index(input logic [NUM_BTN-1:0] b);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_BTN; i++) if (b[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/button_input_debounce.sv
// 2-flop synchroniser plus stable-level debouncer for one raw pad input.
// Level changes DEBOUNCE_CYCLES+2 edges after the raw change; no backpressure.
module button_input_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DB_W            = 18
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw_in,
  output logic db_out
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            db_q, db_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // Any sample that agrees with the stable level restarts the count.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) db_d = ~db_q;
      else                   cnt_d = cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_out = db_q;

endmodule

// File: rtl/button_input.sv
// Debounces colour/start buttons and encodes a single colour press into IN/IN_VALID;
// chords are rejected with a MULTI pulse. DEBOUNCE_CYCLES+3 edges latency; no backpressure.
module button_input
  import button_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int DB_W            = DB_W_DEFAULT
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_BTN-1:0] BTN,
  input  logic               START_BTN,
  output logic [1:0]         IN,
  output logic               IN_VALID,
  output logic               START_GAME,
  output logic               MULTI
);

  logic [NUM_BTN-1:0] db;
  logic               db_start;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_input_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DB_W            (DB_W)
    ) u_db (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .raw_in (BTN[g]),
      .db_out (db[g])
    );
  end

  button_input_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_db_start (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .raw_in (START_BTN),
    .db_out (db_start)
  );

  enc_state_e state_q, state_d;
  logic [1:0] in_q, in_d;
  logic       in_vld_q, in_vld_d;
  logic       multi_q, multi_d;
  logic       start_q, start_d;

  always_comb begin
    state_d  = state_q;
    in_d     = in_q;
    in_vld_d = in_vld_q;
    multi_d  = 1'b0;
    start_d  = db_start;
    case (state_q)
      ENC_IDLE: begin
        if (btn_count(db) == 3'd1) begin
          in_d     = btn_index(db);
          in_vld_d = 1'b1;
          state_d  = ENC_HELD;
        end else if (db != '0) begin
          multi_d = 1'b1;
          state_d = ENC_WAIT;
        end
      end
      // Extra buttons pressed while held are ignored; only the latched one matters.
      ENC_HELD: begin
        if (!db[in_q]) begin
          in_vld_d = 1'b0;
          state_d  = (db == '0) ? ENC_IDLE : ENC_WAIT;
        end
      end
      ENC_WAIT: begin
        if (db == '0) state_d = ENC_IDLE;
      end
      default: state_d = ENC_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ENC_IDLE;
      in_q     <= '0;
      in_vld_q <= 1'b0;
      multi_q  <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_q     <= in_d;
      in_vld_q <= in_vld_d;
      multi_q  <= multi_d;
      start_q  <= start_d;
    end
  end

  assign IN         = in_q;
  assign IN_VALID   = in_vld_q;
  assign MULTI      = multi_q;
  assign START_GAME = start_q;

endmodule
